// File: rtl/noc_pkg.sv
// Shared types and default sizing for the NOC round-robin scheduler.
package noc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2
  } sched_state_t;

  localparam int unsigned NOC_N_SRC  = 4;
  localparam int unsigned NOC_DATA_W = 16;

endpackage : noc_pkg

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          any_req_o,
  output logic [PW-1:0] win_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [PW-1:0]  sel;
  logic [PW:0]    sum;

  assign any_req_o = |req_i;

  always_comb begin
    // Rotate so the pointer position lands on bit 0, then pick the lowest set bit.
    dbl = {req_i, req_i} >> ptr_i;
    rot = dbl[N-1:0];
    sel = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (rot[N-1-k]) sel = PW'(N - 1 - k);
    end
    sum = {1'b0, sel} + {1'b0, ptr_i};
    if (sum >= (PW+1)'(N)) begin
      sum = sum - (PW+1)'(N);
    end
    win_o = sum[PW-1:0];
  end

endmodule : rr_pick

// File: rtl/noc_rr_scheduler.sv
// Round-robin arbiter sharing one NOC destination port, with held packet and ack timeout.
module noc_rr_scheduler
  import noc_pkg::*;
#(
  parameter int unsigned N_SRC       = NOC_N_SRC,
  parameter int unsigned DATA_W      = NOC_DATA_W,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_SRC-1:0]           src_valid,
  input  logic [N_SRC*DATA_W-1:0]    src_data,
  output logic [N_SRC-1:0]           src_ready,
  output logic                       dst_valid,
  output logic [DATA_W-1:0]          dst_data,
  input  logic                       dst_ready,
  input  logic                       ack,
  output logic [$clog2(N_SRC)-1:0]   grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int unsigned GW = $clog2(N_SRC);
  localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);

  sched_state_t      state_q, state_d;
  logic [GW-1:0]     ptr_q, ptr_d;
  logic [GW-1:0]     gid_q, gid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              tmo_q, tmo_d;

  logic              any_req;
  logic [GW-1:0]     win;
  logic [GW-1:0]     next_ptr;
  logic [DATA_W-1:0] win_pkt;

  rr_pick #(
    .N  (N_SRC),
    .PW (GW)
  ) u_pick (
    .req_i     (src_valid),
    .ptr_i     (ptr_q),
    .any_req_o (any_req),
    .win_o     (win)
  );

  assign next_ptr = (gid_q == GW'(N_SRC - 1)) ? '0 : gid_q + 1'b1;

  always_comb begin
    win_pkt = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (win == GW'(i)) win_pkt = src_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gid_d     = gid_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    tmo_d     = 1'b0;
    src_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          for (int unsigned i = 0; i < N_SRC; i++) begin
            src_ready[i] = (win == GW'(i));
          end
          data_d  = win_pkt;
          gid_d   = win;
          state_d = SEND;
        end
      end
      SEND: begin
        if (dst_ready) begin
          cnt_d   = '0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // Ack takes precedence over a timeout landing in the same cycle.
        if (ack) begin
          ptr_d   = next_ptr;
          state_d = IDLE;
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          ptr_d   = next_ptr;
          tmo_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      src_ready = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign dst_valid   = (state_q == SEND);
  assign dst_data    = data_q;
  assign grant_id    = gid_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = tmo_q;

endmodule : noc_rr_scheduler

// File: doc/noc_rr_scheduler.md
Name: noc_rr_scheduler

Overview:
- Shares the single NOC destination port between N_SRC packet sources.
- Round-robin grant; the winner's packet is captured into a holding register, presented to the destination with a valid/ready handshake, then the scheduler waits for the destination ack before re-arbitrating.
- A bounded ack timeout prevents a lost ack from locking the port. Sits between the source-side packet generators and the NOC destination/FIFO.

Parameters:
- N_SRC, 4, number of requesting sources (2..8)
- DATA_W, 16, packet width in bits
- ACK_TIMEOUT, 15, max cycles spent in WAIT_ACK before abort (1..255)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- src_valid  in  N_SRC  per-source packet request
- src_data  in  N_SRC*DATA_W  packed packets; source i at bits [i*DATA_W +: DATA_W]
- src_ready  out  N_SRC  one-hot capture strobe to the granted source
- dst_valid  out  1  packet presented to destination
- dst_data  out  DATA_W  held packet
- dst_ready  in  1  destination accepts
- ack  in  1  destination completion acknowledge
- grant_id  out  $clog2(N_SRC)  index of current/last granted source
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  one-cycle pulse on ack timeout

Behaviour:
- Reset is synchronous, active-high, sampled on posedge clk. Reset values:
  - state=IDLE, rr_ptr=0, grant_id=0
  - src_ready=0, dst_valid=0, dst_data=0, busy=0, timeout_err=0, ack counter=0
- Reset wins over all other inputs in the same cycle.
- A reset mid-packet drops the held packet; no src_ready or dst_valid follows.
- States: IDLE, SEND, WAIT_ACK.
- IDLE:
  - If any src_valid is high, select the first set bit at or after rr_ptr, wrapping modulo N_SRC.
  - Combinationally assert src_ready[win]=1 for that cycle only.
  - At the clock edge: capture src_data[win] into dst_data, set grant_id=win, go to SEND.
  - If no src_valid is high, stay in IDLE with outputs 0.
- SEND:
  - dst_valid=1 with dst_data stable.
  - On dst_valid && dst_ready, go to WAIT_ACK and clear the counter.
  - ack received while in SEND is ignored.
- WAIT_ACK:
  - dst_valid=0. The counter increments each cycle without ack.
  - If ack=1 → IDLE, rr_ptr = grant_id+1 mod N_SRC.
  - Else if the counter reaches ACK_TIMEOUT → timeout_err=1 for exactly one cycle (registered, high in the cycle after the transition edge), IDLE, rr_ptr advances the same as on ack.
  - If ack arrives in the same cycle the counter hits the limit, ack wins and there is no error.
- Latency:
  - Request to dst_valid: 1 cycle (src_ready cycle, then SEND).
  - Minimum packet cycle: IDLE → SEND → WAIT_ACK → IDLE = 3 cycles with immediate dst_ready and ack.
- Fairness: a source that just completed is lowest priority next round; a continuously requesting source waits at most N_SRC-1 packets.
- src_valid may drop before grant; only the IDLE-cycle value matters. Non-granted sources never see src_ready.
- grant_id holds its value after return to IDLE.
- rr_ptr wraps from N_SRC-1 to 0.
- The counter width is $clog2(ACK_TIMEOUT+1) and it must not overflow.

Decomposition:
- Package noc_pkg:
  - state enum sched_state_t {IDLE, SEND, WAIT_ACK} (logic [1:0])
  - default widths DATA_W, N_SRC
- Sub-module rr_pick:
  - Purely combinational.
  - Inputs: req vector, ptr. Outputs: any_req, win index.
  - Implemented as a rotate, priority-encode, un-rotate sequence.
  - Unit-testable standalone.

Test Plan:
- Single source: src_valid=4'b0100, data 16'hA5A5, dst_ready=1, ack one cycle after acceptance
  → src_ready=4'b0100 for 1 cycle, dst_data=16'hA5A5, grant_id=2, rr_ptr=3, back in IDLE after 3 cycles.
- All four sources continuously valid, immediate ready/ack
  → grant_id sequence 0,1,2,3,0,1 and src_ready one-hot matching each grant.
- dst_ready held low 5 cycles in SEND
  → dst_valid=1 and dst_data stable for all 6 SEND cycles; ack pulsed during SEND is ignored; transition to WAIT_ACK only after dst_ready.
- ACK_TIMEOUT=15, ack never returned
  → timeout_err pulses once after 15 WAIT_ACK cycles, state IDLE, next grant skips the timed-out source.
- ack asserted exactly on the 15th WAIT_ACK cycle → no timeout_err, normal return to IDLE.
- reset=1 asserted during WAIT_ACK with a packet held
  → next cycle all outputs 0, rr_ptr=0; the next request from source 3 is granted without any stale dst_valid.
